button_matrix_scanner: RTL and testbench
========================================

BUTTON_MATRIX_SCANNER -- requirements
Module: button_matrix_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each column is driven; legal range is at least 2.
REQ-002 Parameter DEBOUNCE_SCANS, default 4: consecutive identical samples needed to change a debounced level; legal range is 1 to 15.
REQ-003 clock  in  1  the single clock; all state advances on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 col_drive  out  3  column strobes, active-low, exactly one low at a time.
REQ-006 row_sense  in  3  row returns, active-low (pulled up), asynchronous to clock.
REQ-007 btn_level  out  9  debounced pressed levels; bit = row*3+col.
REQ-008 hit_vector  out  9  sticky press events awaiting processor acknowledge.
REQ-009 hit_valid  out  1  OR-reduction of hit_vector.
REQ-010 hit_ack  in  1  single-cycle acknowledge pulse.
REQ-011 ack_mask  in  9  bits of hit_vector cleared when hit_ack=1.

Function
REQ-012 row_sense SHALL pass through a 2-flop synchronizer before any use.
REQ-013 Scan FSM SHALL have states DRIVE and SAMPLE.
- DRIVE lasts SCAN_DIV-1 cycles.
- SAMPLE lasts 1 cycle.
- SAMPLE then goes to DRIVE and advances col_idx 0->1->2->0.
REQ-014 col_drive SHALL equal ~(1<<col_idx), registered; one frame = 3*SCAN_DIV cycles.
REQ-015 In SAMPLE, each button of the active column SHALL take sample = ~synced row bit.
REQ-016 Per button, a 4-bit run counter SHALL behave as follows on each sample.
- Reset the counter to 0 when the sample equals btn_level.
- Otherwise increment the counter.
- When it reaches DEBOUNCE_SCANS, toggle btn_level and clear the counter.
REQ-017 A btn_level 0->1 transition SHALL set the matching hit_vector bit in the same cycle btn_level updates.
- Release (1->0) SHALL NOT set any hit_vector bit.
REQ-018 With hit_ack=1, bits in ack_mask SHALL clear.
- If a set and a clear hit the same bit in the same cycle, the set SHALL win.
- With hit_ack=0, ack_mask SHALL be ignored.
REQ-019 hit_valid SHALL be combinational from hit_vector, with zero-cycle latency.
REQ-020 Worst-case press-to-hit latency SHALL be 2 + DEBOUNCE_SCANS*3*SCAN_DIV cycles.
REQ-021 Simultaneous presses on several buttons SHALL each be registered independently, with no masking.

Reset
REQ-022 While reset=1, the block SHALL hold the following values, asynchronously:
- FSM=DRIVE, col_idx=0, dwell counter=0.
- col_drive=3'b110.
- synchronizers=3'b111.
- run counters=0, btn_level=0, hit_vector=0, hit_valid=0.
REQ-023 Reset asserted mid-frame SHALL discard partial debounce state.
- Scanning SHALL resume at column 0 on the first clock after deassertion.

Configuration
REQ-024 Macro SCANNER_HIT_COUNT_EN SHALL control the hit counter.
- Defined: adds output hit_count [15:0], reset 0, incremented once per press event (summed if several in one cycle), wrapping 0xFFFF->0.
- Undefined: the port and its logic SHALL be absent.

Structure
REQ-025 Shared package mole_pkg SHALL hold NUM_ROWS=3, NUM_COLS=3, NUM_BTNS=9, default SCAN_DIV and DEBOUNCE_SCANS, and the scan-state typedef {DRIVE, SAMPLE}.
REQ-026 Per-button run-counter and level logic SHALL be sub-module btn_debounce, instantiated 9 times; the scan FSM stays in the top module.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2; frame = 12 cycles)
REQ-027 Reset release, no input -> col_drive steps 110, 101, 011 every 4 cycles; hit_valid stays 0.
REQ-028 Button 4 (row1,col1) held low for 3 frames -> btn_level[4]=1 and hit_vector=9'h010 within 2+24 cycles; hit_valid=1.
REQ-029 Glitch on button 4 for one sample only -> btn_level and hit_vector unchanged.
REQ-030 hit_vector=9'h011, hit_ack=1, ack_mask=9'h001 -> hit_vector=9'h010 next cycle.
- Ack on a bit in the same cycle as its new press -> bit remains 1.
REQ-031 Reset pulsed mid-debounce of button 8 -> all outputs return to reset values immediately; no hit until 2 fresh full-debounce frames.
REQ-032 SCANNER_HIT_COUNT_EN defined, buttons 0 and 8 pressed together -> hit_count goes 0->2 in one cycle; starting at 0xFFFF, one press gives 0.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared constants, scan-state type and helpers for the 3x3 button matrix scanner.
package mole_pkg;

  localparam int unsigned NUM_ROWS = 3;
  localparam int unsigned NUM_COLS = 3;
  localparam int unsigned NUM_BTNS = NUM_ROWS * NUM_COLS;

  localparam int unsigned SCAN_DIV_DEFAULT       = 1000;
  localparam int unsigned DEBOUNCE_SCANS_DEFAULT = 4;

  typedef enum logic {
    DRIVE,
    SAMPLE
  } scan_state_e;

  // Number of press events in one cycle; at most NUM_BTNS, fits in 4 bits.
  function automatic logic [3:0] count_ones(input logic [NUM_BTNS-1:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(NUM_BTNS); i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button debouncer: a run counter of consecutive samples disagreeing with the
// debounced level; the level toggles once the run reaches DEBOUNCE_SCANS.
module btn_debounce
  import mole_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic sample_en,
  input  logic sample,
  output logic level,
  output logic press
);

  localparam logic [3:0] RunLimit = 4'(DEBOUNCE_SCANS);

  logic [3:0] run_q, run_d;
  logic       level_q, level_d;

  always_comb begin
    run_d   = run_q;
    level_d = level_q;
    press   = 1'b0;
    if (sample_en) begin
      if (sample == level_q) begin
        run_d = '0;
      end else if (run_q + 4'd1 == RunLimit) begin
        level_d = ~level_q;
        run_d   = '0;
        // Only the released-to-pressed edge is an event.
        press   = ~level_q;
      end else begin
        run_d = run_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_q   <= '0;
      level_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/button_matrix_scanner.sv
// 3x3 active-low button matrix scanner with debounce and sticky press events.
// Optional hit_count output is enabled by defining SCANNER_HIT_COUNT_EN.
module button_matrix_scanner
  import mole_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = SCAN_DIV_DEFAULT,
  parameter int unsigned DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  output logic [NUM_COLS-1:0] col_drive,
  input  logic [NUM_ROWS-1:0] row_sense,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] hit_vector,
  input  logic                hit_ack,
  input  logic [NUM_BTNS-1:0] ack_mask,
`ifdef SCANNER_HIT_COUNT_EN
  output logic                hit_valid,
  output logic [15:0]         hit_count
`else
  output logic                hit_valid
`endif
);

  // Dwell counter only needs to reach SCAN_DIV-2 (last DRIVE cycle).
  localparam int unsigned          DwellW    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV - 1) : 1;
  localparam logic [DwellW-1:0]    DwellLast = DwellW'(SCAN_DIV - 2);

  // Row synchronizer; idle (pulled-up) value is all ones.
  logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row_sense;
      row_sync_q <= row_meta_q;
    end
  end

  // Scan FSM
  scan_state_e         state_q, state_d;
  logic [DwellW-1:0]   dwell_q, dwell_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [NUM_COLS-1:0] col_drive_q;

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    col_idx_d = col_idx_q;
    unique case (state_q)
      DRIVE: begin
        if (dwell_q == DwellLast) begin
          state_d = SAMPLE;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      SAMPLE: begin
        state_d   = DRIVE;
        col_idx_d = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= DRIVE;
      dwell_q     <= '0;
      col_idx_q   <= 2'd0;
      col_drive_q <= 3'b110;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      col_idx_q   <= col_idx_d;
      col_drive_q <= ~(3'b001 << col_idx_d);
    end
  end

  assign col_drive = col_drive_q;

  logic                sampling;
  logic [NUM_BTNS-1:0] press_vec;

  assign sampling = (state_q == SAMPLE);

  for (genvar r = 0; r < int'(NUM_ROWS); r++) begin : g_row
    for (genvar c = 0; c < int'(NUM_COLS); c++) begin : g_col
      btn_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_btn (
        .clock    (clock),
        .reset    (reset),
        .sample_en(sampling && (col_idx_q == 2'(c))),
        .sample   (~row_sync_q[r]),
        .level    (btn_level[r*NUM_COLS+c]),
        .press    (press_vec[r*NUM_COLS+c])
      );
    end
  end

  // Sticky events: acknowledge clears first, a fresh press in the same cycle wins.
  logic [NUM_BTNS-1:0] hit_q, hit_d;

  always_comb begin
    hit_d = hit_q;
    if (hit_ack) begin
      hit_d = hit_d & ~ack_mask;
    end
    hit_d = hit_d | press_vec;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_q <= '0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign hit_vector = hit_q;
  assign hit_valid  = |hit_q;

`ifdef SCANNER_HIT_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 16'(count_ones(press_vec));
    end
  end

  assign hit_count = count_q;
`endif

endmodule

// File: tb/tb_button_matrix_scanner.sv
// Scoreboard bench for button_matrix_scanner with a physical matrix model and
// a frame-level behavioural reference.
module tb_button_matrix_scanner;

  localparam int SD = 4;
  localparam int DB = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] col_drive;
  logic [2:0] row_sense;
  logic [8:0] btn_level, hit_vector, ack_mask;
  logic       hit_valid, hit_ack;
`ifdef SCANNER_HIT_COUNT_EN
  logic [15:0] hit_count;
`endif

  logic [8:0] pressed;

  button_matrix_scanner #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_SCANS(DB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .col_drive (col_drive),
    .row_sense (row_sense),
    .btn_level (btn_level),
    .hit_vector(hit_vector),
    .hit_ack   (hit_ack),
    .ack_mask  (ack_mask),
`ifdef SCANNER_HIT_COUNT_EN
    .hit_valid (hit_valid),
    .hit_count (hit_count)
`else
    .hit_valid (hit_valid)
`endif
  );

  always #5 clock = ~clock;

  // Physical matrix: a pressed button shorts its row to its column.
  always_comb begin
    row_sense = 3'b111;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (pressed[r*3+c] && !col_drive[c]) row_sense[r] = 1'b0;
      end
    end
  end

  typedef struct {
    logic [2:0]  col;
    logic [8:0]  lvl;
    logic [8:0]  hit;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference state
  int          n;
  logic [8:0]  m_lvl, m_hit;
  int          m_run[9];
  logic [15:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    n     = 0;
    m_lvl = '0;
    m_hit = '0;
    m_cnt = '0;
    for (int b = 0; b < 9; b++) m_run[b] = 0;
  endtask

  // Edge n: every SD-th edge samples the column driven during the preceding SD cycles.
  task automatic model_edge();
    logic [8:0] rises;
    logic [2:0] one;
    exp_t e;
    int c;
    int b;
    n++;
    rises = '0;
    if (hit_ack) m_hit = m_hit & ~ack_mask;
    if (n % SD == 0) begin
      c = ((n - 1) / SD) % 3;
      for (int r = 0; r < 3; r++) begin
        b = r * 3 + c;
        if (pressed[b] == m_lvl[b]) begin
          m_run[b] = 0;
        end else begin
          m_run[b]++;
          if (m_run[b] >= DB) begin
            m_lvl[b] = ~m_lvl[b];
            m_run[b] = 0;
            if (m_lvl[b]) rises[b] = 1'b1;
          end
        end
      end
    end
    m_hit = m_hit | rises;
    m_cnt = m_cnt + 16'($countones(rises));
    one   = 3'b001;
    e.col = ~(one << ((n / SD) % 3));
    e.lvl = m_lvl;
    e.hit = m_hit;
    e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  // Button state only changes at column-period boundaries, so each sample is unambiguous.
  task automatic pick_inputs(input int mode);
    hit_ack  = 1'b0;
    ack_mask = '0;
    case (mode)
      1: if (n % SD == 0) pressed = 9'h010;
      2: begin
        if (n % SD == 0) pressed = 9'h101;
        hit_ack  = 1'b1;
        ack_mask = 9'h1ff;
      end
      3: begin
        hit_ack  = ($urandom_range(0, 3) == 0);
        ack_mask = 9'($urandom);
        if (n % SD == 0) begin
          for (int b = 0; b < 9; b++) begin
            if ($urandom_range(0, 5) == 0) pressed[b] = ~pressed[b];
          end
        end
      end
      4: if (n % SD == 0) pressed = 9'h100;
      default: if (n % SD == 0) pressed = 9'h000;
    endcase
  endtask

  task automatic run(input int cycles, input int mode);
    repeat (cycles) begin
      @(posedge clock);
      model_edge();
      #1;
      pick_inputs(mode);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_col_drive"}, 32'(col_drive), 32'h6);
    check({tag, "_btn_level"}, 32'(btn_level), 32'h0);
    check({tag, "_hit_vector"}, 32'(hit_vector), 32'h0);
    check({tag, "_hit_valid"}, 32'(hit_valid), 32'h0);
`ifdef SCANNER_HIT_COUNT_EN
    check({tag, "_hit_count"}, 32'(hit_count), 32'h0);
`endif
  endtask

  // Monitor: compares the DUT against the next expected snapshot each cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("col_drive", 32'(col_drive), 32'(e.col));
        check("btn_level", 32'(btn_level), 32'(e.lvl));
        check("hit_vector", 32'(hit_vector), 32'(e.hit));
        check("hit_valid", 32'(hit_valid), 32'(|e.hit));
`ifdef SCANNER_HIT_COUNT_EN
        check("hit_count", 32'(hit_count), 32'(e.cnt));
`endif
      end
    end
  end

  initial begin : driver
    pressed  = '0;
    hit_ack  = 1'b0;
    ack_mask = '0;
    model_clear();
    repeat (2) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;

    run(36, 0);   // idle: column stepping only
    run(36, 1);   // button 4 held three frames
    run(36, 0);   // release
    run(36, 2);   // buttons 0 and 8 together, acked every cycle
    run(24, 0);
    run(1200, 3); // random presses, glitches and acks
    run(24, 0);
    run(16, 4);   // button 8 part-way through debounce

    @(negedge clock);
    #1 reset = 1'b1;
    #1 check_reset_values("midreset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_clear();

    run(48, 4);   // needs two fresh samples before the hit
    run(600, 3);
    run(24, 0);

    @(negedge clock);
    #1;
    check("scoreboard_drain", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
